// File: rtl/serial_loader.sv
// serial_loader: parallel-to-serial front end for a small shift register.
// A word accepted on the valid/ready handshake is sent out one bit per strobe.
// GAP idle cycles can be inserted between bits. The last bit carries a
// frame_done pulse. Outputs depend only on registered state. The one exception
// is load_ready, which is also held low while reset is asserted.
module serial_loader #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             shift_enable,
  output logic             shift_data,
  output logic             frame_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  // GAP-1 is only loaded when GAP is nonzero; guard the subtraction anyway.
  localparam logic [3:0] GAP_RELOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [WIDTH-1:0] hold;
  logic [CW-1:0]    bit_cnt;
  logic [3:0]       gap_cnt;
  logic             last_bit;

  assign last_bit = (bit_cnt == LAST_BIT);

  // State register; reset always returns to IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    next_state   = state;
    load_ready   = 1'b0;
    shift_enable = 1'b0;
    shift_data   = 1'b0;
    frame_done   = 1'b0;
    case (state)
      IDLE: begin
        // Gating with reset means a word offered during reset is never taken.
        load_ready = !reset;
        if (load_valid && !reset) begin
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        shift_enable = 1'b1;
        shift_data   = MSB_FIRST ? hold[WIDTH-1] : hold[0];
        frame_done   = last_bit;
        if (last_bit) begin
          next_state = IDLE;
        end else if (GAP != 0) begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (gap_cnt == 4'd0) begin
          next_state = SHIFT;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Word holding register, bit counter and gap counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold    <= '0;
      bit_cnt <= '0;
      gap_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            hold    <= load_data;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          // Move the next bit toward the output end, zero-filling behind it.
          hold    <= MSB_FIRST ? (hold << 1) : (hold >> 1);
          bit_cnt <= bit_cnt + 1'b1;
          if (!last_bit && (GAP != 0)) begin
            gap_cnt <= GAP_RELOAD;
          end
        end
        WAIT: begin
          gap_cnt <= gap_cnt - 4'd1;
        end
        default: begin
          hold <= hold;
        end
      endcase
    end
  end

endmodule
